// File: rtl/score_time_bcd_packer.sv
`default_nettype none
//============================================================================
// Module      : score_time_bcd_packer
// Description : Converts the binary game score and the remaining-time value
//               into six packed BCD digits for the seven-segment display.
//               A single shift-add-3 (double-dabble) engine converts time
//               first (7 bits), then score (14 bits), one bit per cycle.
//               The result is loaded onto number_sig in one step, so the
//               display never shows a half-converted number.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   update     in   1   single-cycle conversion request
//   score      in  14   binary score, unsigned (saturated to 9999)
//   time_left  in   7   binary seconds remaining (saturated to 99)
//   number_sig out 24   packed BCD {tT,tO,sTh,sH,sT,sO}
//   busy       out  1   conversion in progress (CONV_T / CONV_S)
//   done       out  1   one-cycle pulse, first cycle the new value is valid
//============================================================================
module score_time_bcd_packer #(
    parameter logic [23:0] REFRESH_CYCLES = 24'd4999999,
    parameter int          SCORE_W        = 14,
    parameter int          TIME_W         = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               update,
    input  logic [SCORE_W-1:0] score,
    input  logic [TIME_W-1:0]  time_left,
    output logic [23:0]        number_sig,
    output logic               busy,
    output logic               done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CONV_T = 2'd1;
    localparam logic [1:0] c_ST_CONV_S = 2'd2;
    localparam logic [1:0] c_ST_LOAD   = 2'd3;

    localparam logic [SCORE_W-1:0] c_SCORE_MAX = SCORE_W'(9999);
    localparam logic [TIME_W-1:0]  c_TIME_MAX  = TIME_W'(99);
    localparam logic [3:0]         c_TIME_LAST  = 4'(TIME_W - 1);
    localparam logic [3:0]         c_SCORE_LAST = 4'(SCORE_W - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [TIME_W-1:0]  r_top;        // time operand, shifted out MSB first
    logic [SCORE_W-1:0] r_sop;        // score operand, shifted out MSB first
    logic [15:0]        r_acc;        // shared 4-digit BCD accumulator
    logic [7:0]         r_tres;       // finished time digits, held for LOAD
    logic [3:0]         r_bitcnt;
    logic               r_pending;
    logic [23:0]        r_refresh_cnt;
    logic [23:0]        r_number;
    logic               r_done;

    logic               w_refresh_hit;
    logic               w_req;
    logic               w_start;
    logic               w_last_bit;
    logic               w_busy;
    logic               w_shift_en;
    logic               w_time_phase;
    logic               w_load;
    logic               w_bit_in;
    logic [11:0]        w_adj_lo;
    logic [2:0]         w_adj_top;
    logic [15:0]        w_acc_nxt;

    // ------------------------------------------------------------------
    // Request generation
    // ------------------------------------------------------------------
    // A zero period disables the automatic refresh entirely.
    assign w_refresh_hit = (REFRESH_CYCLES != 24'd0) &&
                           (r_refresh_cnt == (REFRESH_CYCLES - 24'd1));
    assign w_req         = update | w_refresh_hit;

    // Requests seen outside IDLE were parked in r_pending; IDLE honours
    // both the live request and the parked one.
    assign w_start       = (r_state == c_ST_IDLE) && (w_req || r_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= 24'd0;
        end else if ((REFRESH_CYCLES == 24'd0) || w_refresh_hit) begin
            r_refresh_cnt <= 24'd0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_pending <= 1'b0;
        end else if (w_req && (r_state != c_ST_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last shift of the current operand.
    assign w_last_bit = ((r_state == c_ST_CONV_T) && (r_bitcnt == c_TIME_LAST)) ||
                        ((r_state == c_ST_CONV_S) && (r_bitcnt == c_SCORE_LAST));

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_CONV_T;
                end
            end
            c_ST_CONV_T: begin
                if (w_last_bit) begin
                    w_state_nxt = c_ST_CONV_S;
                end
            end
            c_ST_CONV_S: begin
                if (w_last_bit) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy       = 1'b0;
        w_shift_en   = 1'b0;
        w_time_phase = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            c_ST_CONV_T: begin
                w_busy       = 1'b1;
                w_shift_en   = 1'b1;
                w_time_phase = 1'b1;
            end
            c_ST_CONV_S: begin
                w_busy     = 1'b1;
                w_shift_en = 1'b1;
            end
            c_ST_LOAD: begin
                w_load = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared double-dabble step
    // ------------------------------------------------------------------
    assign w_bit_in = w_time_phase ? r_top[TIME_W-1] : r_sop[SCORE_W-1];

    // Add 3 to every nibble that is 5 or more, then shift in the next bit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj_lo[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                         (r_acc[gi*4 +: 4] + 4'd3) :
                                          r_acc[gi*4 +: 4];
        end
    endgenerate

    // The top digit's MSB is shifted out and lost, so only its low three
    // adjusted bits are kept; valid BCD never carries anything out of it.
    assign w_adj_top = (r_acc[15:12] >= 4'd5) ? (r_acc[14:12] + 3'd3) : r_acc[14:12];
    assign w_acc_nxt = {w_adj_top, w_adj_lo, w_bit_in};

    // ------------------------------------------------------------------
    // Datapath: operand capture and shifting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top    <= '0;
            r_sop    <= '0;
            r_acc    <= 16'd0;
            r_tres   <= 8'd0;
            r_bitcnt <= 4'd0;
        end else if (w_start) begin
            // Saturate out-of-range inputs to the largest displayable value.
            r_top    <= (time_left > c_TIME_MAX) ? c_TIME_MAX : time_left;
            r_sop    <= (score > c_SCORE_MAX) ? c_SCORE_MAX : score;
            r_acc    <= 16'd0;
            r_tres   <= 8'd0;
            r_bitcnt <= 4'd0;
        end else if (w_shift_en) begin
            r_bitcnt <= w_last_bit ? 4'd0 : (r_bitcnt + 4'd1);
            if (w_time_phase) begin
                r_top <= {r_top[TIME_W-2:0], 1'b0};
                if (w_last_bit) begin
                    // Time finished: park its digits and free the engine
                    // for the score.
                    r_tres <= w_acc_nxt[7:0];
                    r_acc  <= 16'd0;
                end else begin
                    r_acc <= w_acc_nxt;
                end
            end else begin
                r_sop <= {r_sop[SCORE_W-2:0], 1'b0};
                r_acc <= w_acc_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: both fields move onto the bus together
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_number <= 24'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_number <= {r_tres, r_acc};
            end
        end
    end

    assign number_sig = r_number;
    assign busy       = w_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_score_time_bcd_packer.sv
`default_nettype none
//============================================================================
// Module      : tb_score_time_bcd_packer
// Description : Self-checking bench for score_time_bcd_packer. Two instances
//               share the operand inputs: one with auto refresh disabled
//               (driven by update), one with a 50-cycle refresh period.
//               A cycle-level behavioural model predicts busy/done/number_sig.
// Revision    : 1.0 - initial release
//============================================================================
module tb_score_time_bcd_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd0;
    logic        upd1;
    logic [13:0] score;
    logic [6:0]  tl;
    logic [23:0] ns0, ns1;
    logic        busy0, busy1, done0, done1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_time_bcd_packer #(.REFRESH_CYCLES(24'd0)) dut (
        .clk(clk), .rst(rst), .update(upd0), .score(score), .time_left(tl),
        .number_sig(ns0), .busy(busy0), .done(done0)
    );

    score_time_bcd_packer #(.REFRESH_CYCLES(24'd50)) dut_r (
        .clk(clk), .rst(rst), .update(upd1), .score(score), .time_left(tl),
        .number_sig(ns1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bcd6(input int t, input int s);
        return {4'(t / 10), 4'(t % 10), 4'(s / 1000), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: m_t counts cycles since the request was taken
    // (0 = idle, 1..21 converting, 22 = final cycle before the new value).
    // ------------------------------------------------------------------
    int          m_cnt [2];
    int          m_t   [2];
    bit          m_pend[2];
    int          m_ts  [2];
    int          m_ss  [2];
    logic [23:0] m_num [2];
    bit          m_done[2];

    initial begin
        int  per;
        bit  hit;
        bit  req;
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_cnt[i] = 0; m_t[i] = 0; m_pend[i] = 0;
                    m_ts[i] = 0; m_ss[i] = 0; m_num[i] = 24'd0; m_done[i] = 0;
                end else begin
                    per = (i == 0) ? 0 : 50;
                    hit = (per != 0) && (m_cnt[i] == per - 1);
                    m_cnt[i] = (per == 0 || hit) ? 0 : m_cnt[i] + 1;
                    req = hit || ((i == 0) ? upd0 : upd1);
                    m_done[i] = 0;
                    if (m_t[i] == 0) begin
                        if (req || m_pend[i]) begin
                            m_pend[i] = 0;
                            m_ts[i] = (int'(tl) > 99) ? 99 : int'(tl);
                            m_ss[i] = (int'(score) > 9999) ? 9999 : int'(score);
                            m_t[i] = 1;
                        end
                    end else begin
                        if (req) m_pend[i] = 1;
                        if (m_t[i] == 22) begin
                            m_num[i]  = bcd6(m_ts[i], m_ss[i]);
                            m_done[i] = 1;
                            m_t[i]    = 0;
                        end else begin
                            m_t[i] = m_t[i] + 1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus done/busy bookkeeping
    // ------------------------------------------------------------------
    int n_done0 = 0, n_busy0 = 0;
    int last_done1 = -1, prev_done1 = -1;

    initial begin
        forever begin
            @(negedge clk);
            chk("busy0", 24'(busy0), 24'(m_t[0] >= 1 && m_t[0] <= 21));
            chk("done0", 24'(done0), 24'(m_done[0]));
            chk("num0",  ns0, m_num[0]);
            chk("busy1", 24'(busy1), 24'(m_t[1] >= 1 && m_t[1] <= 21));
            chk("done1", 24'(done1), 24'(m_done[1]));
            chk("num1",  ns1, m_num[1]);
            if (!rst && done0) n_done0++;
            if (!rst && busy0) n_busy0++;
            if (!rst && done1) begin
                prev_done1 = last_done1;
                last_done1 = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    int kcyc;

    // Request sampled at the next rising edge; returns at the following
    // falling edge with kcyc holding that edge's number.
    task automatic pulse_update();
        @(negedge clk);
        upd0 = 1'b1;
        kcyc = cyc + 1;
        @(negedge clk);
        upd0 = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int kstart, input int lat,
                             input logic [23:0] exp);
        bit got = 0;
        for (int j = 0; j < 80 && !got; j++) begin
            @(negedge clk);
            #1;
            if (done0) got = 1;
        end
        if (!got) begin
            chk({nm, "_timeout"}, 24'd0, 24'd1);
        end else begin
            chk({nm, "_lat"}, 24'(cyc - kstart), 24'(lat));
            chk({nm, "_val"}, ns0, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int b0, d0, k0;
        upd0 = 0; upd1 = 0; score = 14'd0; tl = 7'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_num", ns0, 24'h000000);
        chk("rst_busy", 24'(busy0), 24'd0);
        chk("rst_done", 24'(done0), 24'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic conversion, busy length, latency
        score = 14'd1234; tl = 7'd56;
        b0 = n_busy0;
        pulse_update();
        wait_done("t1", kcyc, 22, 24'h561234);
        chk("t1_busy_cycles", 24'(n_busy0 - b0), 24'd21);
        chk("t1_model", m_num[0], 24'h561234);

        // Zeros, then single digits
        score = 14'd0; tl = 7'd0;
        pulse_update();
        wait_done("zero", kcyc, 22, 24'h000000);
        score = 14'd9; tl = 7'd9;
        pulse_update();
        wait_done("nine", kcyc, 22, 24'h090009);

        // Saturation on both fields
        score = 14'd12000; tl = 7'd127;
        pulse_update();
        wait_done("sat", kcyc, 22, 24'h999999);
        chk("sat_model", m_num[0], 24'h999999);

        // Request during conversion becomes pending; operand change after
        // capture is ignored by the first conversion
        score = 14'd1234; tl = 7'd56;
        d0 = n_done0;
        pulse_update();
        k0 = kcyc;
        repeat (4) @(negedge clk);
        score = 14'd4321;
        upd0 = 1'b1;
        @(negedge clk);
        upd0 = 1'b0;
        wait_done("pend1", k0, 22, 24'h561234);
        wait_done("pend2", k0, 45, 24'h564321);
        repeat (40) @(negedge clk);
        chk("pend_done_count", 24'(n_done0 - d0), 24'd2);

        // Auto refresh instance
        score = 14'd777; tl = 7'd30;
        repeat (130) @(negedge clk);
        chk("refresh_val", ns1, 24'h300777);
        chk("refresh_period", 24'(last_done1 - prev_done1), 24'd50);

        // Reset during a conversion
        pulse_update();
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_num", ns0, 24'h000000);
        chk("midrst_busy", 24'(busy0), 24'd0);
        chk("midrst_done", 24'(done0), 24'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 24'(n_done0 - d0), 24'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            score = 14'($urandom_range(0, 16383));
            tl    = 7'($urandom_range(0, 127));
            upd0  = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        upd0 = 1'b0;
        repeat (60) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
